decode_queue: RTL and testbench

- Registered, parametrised successor to the combinational control decoder.
- Decodes each incoming instruction into the full control bundle and captures the bundle with its PC into a DEPTH-entry FIFO.
- Presents the FIFO head downstream through a valid/ready handshake.
- Sits between fetch and the ID/EX boundary. Adds illegal-instruction detection, back-pressure and flush, which a pure decoder cannot provide.

---
 rtl/decode_queue.sv | 187 ++++++++++++++++++
 tb/tb_decode_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// Decodes each fetched instruction into a control bundle and queues it with its PC in a DEPTH-entry FIFO.
// Define DECODE_QUEUE_MULDIV_EN to accept R-type funct7=0000001 (mul/div) encodings and store out_muldiv.
module decode_queue #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 2,
  parameter int ALU_OP_W = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [XLEN-1:0]                  in_instr,
  input  logic [XLEN-1:0]                  in_pc,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [XLEN-1:0]                  out_instr,
  output logic [XLEN-1:0]                  out_pc,
  output logic [12+ALU_OP_W:0]             out_ctrl,
  output logic [3:0]                       out_muldiv,
  output logic [$clog2(DEPTH+1)-1:0]       count
);
  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int CW    = 13 + ALU_OP_W;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(9);
  localparam logic [ALU_OP_W-1:0] ALU_LUI  = ALU_OP_W'(10);

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       br, mrd, m2r, mwr, asrc, rwr, isbr, isj, isjal, isjalr, isld, isst, ill;
  logic [ALU_OP_W-1:0] alu;
  logic [CW-1:0]       ctrl_dec;
  logic [3:0]          md_dec;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  always_comb begin
    case (f3)
      3'd0:    alu = ALU_ADD;
      3'd1:    alu = ALU_SLL;
      3'd2:    alu = ALU_SLT;
      3'd3:    alu = ALU_SLTU;
      3'd4:    alu = ALU_XOR;
      3'd5:    alu = ALU_SRL;
      3'd6:    alu = ALU_OR;
      default: alu = ALU_AND;
    endcase
    {br, mrd, m2r, mwr, asrc, rwr, isbr, isj, isjal, isjalr, isld, isst, ill} = '0;
    md_dec = '0;
    case (opc)
      OP_R: begin
        rwr = 1'b1;
        if (f7 == 7'h20) begin
          if (f3 == 3'd0)      alu = ALU_SUB;
          else if (f3 == 3'd5) alu = ALU_SRA;
          else                 ill = 1'b1;
        end else if (f7 == 7'h01) begin
`ifdef DECODE_QUEUE_MULDIV_EN
          alu    = ALU_ADD;
          md_dec = {1'b1, f3};
`else
          ill = 1'b1;
`endif
        end else if (f7 != 7'h00) begin
          ill = 1'b1;
        end
      end
      OP_IMM: begin
        rwr  = 1'b1;
        asrc = 1'b1;
        // shift-immediates reuse funct7 as an opcode extension
        if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20)      alu = ALU_SRA;
          else if (f7 != 7'h00) ill = 1'b1;
        end
      end
      OP_LOAD:   begin alu = ALU_ADD; mrd = 1'b1; m2r = 1'b1; rwr = 1'b1; asrc = 1'b1; isld = 1'b1; end
      OP_STORE:  begin alu = ALU_ADD; mwr = 1'b1; asrc = 1'b1; isst = 1'b1; end
      OP_BRANCH: begin alu = ALU_SUB; br = 1'b1; isbr = 1'b1; end
      OP_LUI:    begin alu = ALU_LUI; rwr = 1'b1; asrc = 1'b1; end
      OP_AUIPC:  begin alu = ALU_ADD; rwr = 1'b1; asrc = 1'b1; end
      OP_JAL:    begin alu = ALU_ADD; rwr = 1'b1; isj = 1'b1; isjal = 1'b1; end
      OP_JALR:   begin alu = ALU_ADD; rwr = 1'b1; asrc = 1'b1; isj = 1'b1; isjalr = 1'b1; end
      default:   ill = 1'b1;
    endcase
    if (ill) begin
      {br, mrd, m2r, mwr, asrc, rwr, isbr, isj, isjal, isjalr, isld, isst} = '0;
      alu    = ALU_ADD;
      md_dec = '0;
    end
  end

  assign ctrl_dec = {br, mrd, m2r, alu, mwr, asrc, rwr, isbr, isj, isjal, isjalr, isld, isst, ill};

  logic [DEPTH-1:0][XLEN-1:0] instr_q, pc_q;
  logic [DEPTH-1:0][CW-1:0]   ctrl_q;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       in_ready_q, in_ready_d;
  logic                       push, pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
    end
    // registered so a same-cycle pop never lets a full queue accept
    in_ready_d = (count_d != CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      ctrl_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      if (push && !flush) begin
        instr_q[wr_ptr_q] <= in_instr;
        pc_q[wr_ptr_q]    <= in_pc;
        ctrl_q[wr_ptr_q]  <= ctrl_dec;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign count     = count_q;
  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? instr_q[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? pc_q[rd_ptr_q]    : '0;
  assign out_ctrl  = out_valid ? ctrl_q[rd_ptr_q]  : '0;

`ifdef DECODE_QUEUE_MULDIV_EN
  logic [DEPTH-1:0][3:0] md_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 md_q <= '0;
    else if (push && !flush)    md_q[wr_ptr_q] <= md_dec;
  end
  assign out_muldiv = out_valid ? md_q[rd_ptr_q] : '0;
`else
  assign out_muldiv = 4'b0;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: a reference decoder fills a queue on accept, head is checked every cycle.
module tb_decode_queue;
  localparam int XLEN = 32, DEPTH = 2, AW = 4, CW = 13 + AW;

  logic            clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0]     in_instr = '0, in_pc = '0;
  logic            in_ready, out_valid;
  logic [31:0]     out_instr, out_pc;
  logic [CW-1:0]   out_ctrl;
  logic [3:0]      out_muldiv;
  logic [1:0]      count;

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .ALU_OP_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_ctrl(out_ctrl), .out_muldiv(out_muldiv),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic [CW-1:0] ctrl;
    logic [3:0]    md;
  } ent_t;

  ent_t sb[$];
  logic exp_rdy;
  int   n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference decoder, field by field from the RV32I map
  function automatic ent_t ref_dec(input logic [31:0] i, input logic [31:0] pc);
    logic [6:0] op, f7; logic [2:0] f3;
    logic br, mr, m2r, mw, as, rw, ib, ij, ijl, ijr, il, is, ill;
    logic [AW-1:0] alu; logic [3:0] md; ent_t e;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    {br, mr, m2r, mw, as, rw, ib, ij, ijl, ijr, il, is, ill} = '0;
    alu = 4'd0; md = 4'd0;
    case (op)
      7'h33: begin
        rw = 1;
        if (f7 == 7'h00) begin
          case (f3) 0: alu = 0; 1: alu = 2; 2: alu = 3; 3: alu = 4;
                    4: alu = 5; 5: alu = 6; 6: alu = 8; default: alu = 9; endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) alu = 1;
        else if (f7 == 7'h20 && f3 == 3'd5) alu = 7;
`ifdef DECODE_QUEUE_MULDIV_EN
        else if (f7 == 7'h01) md = {1'b1, f3};
`endif
        else ill = 1;
      end
      7'h13: begin
        rw = 1; as = 1;
        case (f3) 0: alu = 0; 2: alu = 3; 3: alu = 4; 4: alu = 5; 6: alu = 8; 7: alu = 9;
          1: begin alu = 2; ill = (f7 != 0); end
          default: begin
            if (f7 == 7'h00) alu = 6; else if (f7 == 7'h20) alu = 7; else ill = 1;
          end
        endcase
      end
      7'h03: begin mr = 1; m2r = 1; rw = 1; as = 1; il = 1; end
      7'h23: begin mw = 1; as = 1; is = 1; end
      7'h63: begin br = 1; ib = 1; alu = 1; end
      7'h37: begin rw = 1; as = 1; alu = 10; end
      7'h17: begin rw = 1; as = 1; end
      7'h6F: begin rw = 1; ij = 1; ijl = 1; end
      7'h67: begin rw = 1; as = 1; ij = 1; ijr = 1; end
      default: ill = 1;
    endcase
    if (ill) begin
      {br, mr, m2r, mw, as, rw, ib, ij, ijl, ijr, il, is} = '0;
      alu = 0; md = 0;
    end
    e.instr = i; e.pc = pc; e.md = md;
    e.ctrl = {br, mr, m2r, alu, mw, as, rw, ib, ij, ijl, ijr, il, is, ill};
    return e;
  endfunction

  // One clock cycle: drive at negedge, check state and resolve handshake before the posedge
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    logic push, pop;
    @(negedge clk);
    in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #2;
    chk("in_ready", in_ready, exp_rdy);
    chk("count", count, sb.size());
    chk("out_valid", out_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      chk("head_instr", out_instr, sb[0].instr);
      chk("head_pc", out_pc, sb[0].pc);
      chk("head_ctrl", out_ctrl, sb[0].ctrl);
      chk("head_muldiv", out_muldiv, sb[0].md);
    end else begin
      chk("empty_instr", out_instr, 0);
      chk("empty_pc", out_pc, 0);
      chk("empty_ctrl", out_ctrl, 0);
    end
    push = iv & exp_rdy;
    pop  = (sb.size() != 0) & ordy;
    if (fl) sb.delete();
    else begin
      if (pop)  void'(sb.pop_front());
      if (push) sb.push_back(ref_dec(ins, pc));
    end
    exp_rdy = (sb.size() != DEPTH);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ctrl", out_ctrl, 0);
    sb.delete();
    @(negedge clk); @(negedge clk);
    #1 rst_n = 1'b1;
    #1 chk("rdy_after_rst", in_ready, 0);
    exp_rdy = 1'b1;
  endtask

  logic [31:0] prog [11];

  initial begin
    prog = '{32'h00500093, 32'h402081B3, 32'h0000A283, 32'h0020A023, 32'h00208463, 32'h123450B7,
             32'h008000EF, 32'h000080E7, 32'h00001097, 32'h0020C1B3, 32'h4020D093};
    exp_rdy = 1'b0;
    do_reset();

    // addi accepted and consumed straight away
    step(1, 32'h00500093, 32'h0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // back-pressure: fill with sub, lw; third offer refused; head held stable
    step(1, 32'h402081B3, 32'h4, 0, 0);
    step(1, 32'h0000A283, 32'h8, 0, 0);
    step(1, 32'h00500093, 32'hC, 0, 0);
    step(1, 32'h00500093, 32'hC, 0, 0);
    // full with push+pop same cycle: pop only, then accepted next edge
    step(1, 32'h00500093, 32'hC, 1, 0);
    step(1, 32'h00500093, 32'hC, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // streaming with random back-pressure to exercise pointer wrap
    for (int k = 0; k < 24; k++)
      step(1, prog[k % 11], 32'h100 + 32'(4 * k), 1'($urandom_range(0, 1)), 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0);

    // illegal encodings (plus the mul encoding) and a legal AND for contrast
    step(1, 32'hFFFFFFFF, 32'h200, 1, 0);
    step(1, 32'h4020F1B3, 32'h204, 1, 0);
    step(1, 32'h40109093, 32'h208, 1, 0);
    step(1, 32'h0020F1B3, 32'h20C, 1, 0);
    step(1, 32'h022081B3, 32'h210, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // flush on a full queue with an offer, then flush overriding an accepted push and a pop
    step(1, 32'h00500093, 32'h300, 0, 0);
    step(1, 32'h402081B3, 32'h304, 0, 0);
    step(1, 32'h0000A283, 32'h308, 0, 1);
    step(1, 32'h00500093, 32'h30C, 0, 0);
    step(1, 32'h0020A023, 32'h310, 1, 1);
    step(0, 0, 0, 1, 0);

    // asynchronous reset with entries queued
    step(1, 32'h00500093, 32'h400, 0, 0);
    step(1, 32'h402081B3, 32'h404, 0, 0);
    do_reset();
    step(1, 32'h0000A283, 32'h500, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
